// File: rtl/vdp_pkg.sv
// Shared VDP CPU-port types: VRAM map, control commands, status bit and FSM states.
package vdp_pkg;
  localparam int VDP_NREGS = 8;

  localparam int NAME_BASE     = 'h0000;
  localparam int NAME_LIMIT    = 'h03FF;
  localparam int COLOUR_BASE   = 'h0400;
  localparam int COLOUR_LIMIT  = 'h07FF;
  localparam int PATTERN_BASE  = 'h0800;
  localparam int PATTERN_LIMIT = 'h0FFF;

  localparam logic [1:0] CMD_REG   = 2'b10;
  localparam logic [1:0] CMD_WADDR = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b00;

  localparam int STATUS_FRAME_BIT = 7;

  typedef enum logic {IDLE, HAVE_BYTE1} ctl_state_t;
  typedef enum logic [1:0] {PF_IDLE, PF_ISSUE, PF_CAPTURE} pf_state_t;
  typedef enum logic [1:0] {TGT_NONE, TGT_NAME, TGT_COLOUR, TGT_PATTERN} vram_tgt_t;

  typedef struct packed {
    vram_tgt_t   tgt;
    logic [10:0] addr;
  } vram_sel_t;
endpackage

// File: rtl/vdp_vram_decode.sv
// Maps a VRAM counter value onto one of the three table RAMs plus its local address.
module vdp_vram_decode
  import vdp_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic [ADDR_W-1:0] addr,
  output vram_sel_t         sel
);
  int unsigned a;

  always_comb begin
    a        = 32'(addr);
    sel.tgt  = TGT_NONE;
    sel.addr = '0;
    if (a <= NAME_LIMIT) begin
      sel.tgt  = TGT_NAME;
      sel.addr = 11'(a - NAME_BASE);
    end else if (a <= COLOUR_LIMIT) begin
      sel.tgt  = TGT_COLOUR;
      sel.addr = 11'(a - COLOUR_BASE);
    end else if (a <= PATTERN_LIMIT) begin
      sel.tgt  = TGT_PATTERN;
      sel.addr = 11'(a - PATTERN_BASE);
    end
  end
endmodule

// File: rtl/vdp_cpu_port.sv
// VDP host port: VRAM writes/readback, control registers R0-R7, status byte and frame IRQ.
// Define VDP_READBACK_EN to build the read-ahead buffer and prefetch FSM.
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int NREGS  = VDP_NREGS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_wr,
  input  logic               cpu_rd,
  input  logic               cpu_mode,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic [9:0]         name_waddr,
  output logic [7:0]         name_wdata,
  output logic               name_we,
  output logic [10:0]        pattern_waddr,
  output logic [7:0]         pattern_wdata,
  output logic               pattern_we,
  output logic [9:0]         colour_waddr,
  output logic [7:0]         colour_wdata,
  output logic               colour_we,
  output logic               vram_rd_en,
  output logic [ADDR_W-1:0]  vram_rd_addr,
  input  logic [7:0]         vram_rd_data,
  input  logic               frame_pulse,
  output logic [NREGS*8-1:0] vdp_regs,
  output logic               irq
);
  ctl_state_t        ctl_state;
  logic [7:0]        byte1;
  logic [ADDR_W-1:0] addr;
  logic              frame_flag;
  logic              pf_ok, wr, rd, data_wr, ctl_wr, data_rd, stat_rd, cmd_valid;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        rd_buf;
  vram_sel_t         wsel;

  vdp_vram_decode #(.ADDR_W(ADDR_W)) u_decode (.addr(addr), .sel(wsel));

  // A write wins over a simultaneous read; anything arriving mid-prefetch is dropped.
  assign wr        = cpu_wr & pf_ok;
  assign rd        = cpu_rd & ~cpu_wr & pf_ok;
  assign data_wr   = wr & ~cpu_mode;
  assign ctl_wr    = wr & cpu_mode;
  assign data_rd   = rd & ~cpu_mode;
  assign stat_rd   = rd & cpu_mode;
  assign cmd_valid = ctl_wr && (ctl_state == HAVE_BYTE1);
  assign cmd_addr  = ADDR_W'({cpu_wdata[5:0], byte1});
  assign irq       = frame_flag & vdp_regs[8 + 5];

`ifdef VDP_READBACK_EN
  pf_state_t         pf_state;
  logic              pf_go;
  logic [ADDR_W-1:0] pf_addr;

  assign pf_ok   = (pf_state == PF_IDLE);
  assign pf_go   = data_rd | (cmd_valid && (cpu_wdata[7:6] == CMD_RADDR));
  assign pf_addr = data_rd ? addr + 1'b1 : cmd_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      pf_state     <= PF_IDLE;
      rd_buf       <= '0;
      vram_rd_en   <= 1'b0;
      vram_rd_addr <= '0;
    end else begin
      case (pf_state)
        PF_ISSUE: begin
          pf_state   <= PF_CAPTURE;
          vram_rd_en <= 1'b0;
        end
        PF_CAPTURE: begin
          pf_state <= PF_IDLE;
          rd_buf   <= vram_rd_data;
        end
        default: begin
          if (pf_go) begin
            pf_state     <= PF_ISSUE;
            vram_rd_en   <= 1'b1;
            vram_rd_addr <= pf_addr;
          end
          if (data_wr) rd_buf <= cpu_wdata;
        end
      endcase
    end
  end
`else
  logic unused_rd_data;

  assign pf_ok          = 1'b1;
  assign rd_buf         = '0;
  assign vram_rd_en     = 1'b0;
  assign vram_rd_addr   = '0;
  assign unused_rd_data = ^vram_rd_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_state     <= IDLE;
      byte1         <= '0;
      addr          <= '0;
      frame_flag    <= 1'b0;
      cpu_rdata     <= '0;
      vdp_regs      <= '0;
      name_we       <= 1'b0;
      name_waddr    <= '0;
      name_wdata    <= '0;
      colour_we     <= 1'b0;
      colour_waddr  <= '0;
      colour_wdata  <= '0;
      pattern_we    <= 1'b0;
      pattern_waddr <= '0;
      pattern_wdata <= '0;
    end else begin
      name_we    <= 1'b0;
      colour_we  <= 1'b0;
      pattern_we <= 1'b0;
      if (frame_pulse) frame_flag <= 1'b1;
      if (data_wr | data_rd | stat_rd) ctl_state <= IDLE;

      if (data_wr) begin
        case (wsel.tgt)
          TGT_NAME: begin
            name_we    <= 1'b1;
            name_waddr <= wsel.addr[9:0];
            name_wdata <= cpu_wdata;
          end
          TGT_COLOUR: begin
            colour_we    <= 1'b1;
            colour_waddr <= wsel.addr[9:0];
            colour_wdata <= cpu_wdata;
          end
          TGT_PATTERN: begin
            pattern_we    <= 1'b1;
            pattern_waddr <= wsel.addr;
            pattern_wdata <= cpu_wdata;
          end
          default: ;
        endcase
        addr <= addr + 1'b1;
      end

      if (ctl_wr) begin
        if (ctl_state == IDLE) begin
          byte1     <= cpu_wdata;
          ctl_state <= HAVE_BYTE1;
        end else begin
          ctl_state <= IDLE;
          // Read setup loads the address too; the prefetch side is handled above.
          case (cpu_wdata[7:6])
            CMD_REG:
              if (int'(cpu_wdata[2:0]) < NREGS)
                vdp_regs[int'(cpu_wdata[2:0])*8 +: 8] <= byte1;
            CMD_WADDR, CMD_RADDR: addr <= cmd_addr;
            default: ;
          endcase
        end
      end

      if (data_rd) begin
        cpu_rdata <= rd_buf;
        addr      <= addr + 1'b1;
      end

      if (stat_rd) begin
        cpu_rdata                   <= '0;
        cpu_rdata[STATUS_FRAME_BIT] <= frame_flag;
        if (!frame_pulse) frame_flag <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vdp_cpu_port.sv
// Randomized bench for vdp_cpu_port against a byte-level VRAM/register reference model.
module tb_vdp_cpu_port;
`ifdef VDP_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_wr = 1'b0, cpu_rd = 1'b0, cpu_mode = 1'b0, frame_pulse = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic [9:0]  name_waddr, colour_waddr;
  logic [10:0] pattern_waddr;
  logic [7:0]  name_wdata, colour_wdata, pattern_wdata;
  logic        name_we, colour_we, pattern_we;
  logic        vram_rd_en;
  logic [13:0] vram_rd_addr;
  logic [7:0]  vram_rd_data = '0;
  logic [63:0] vdp_regs;
  logic        irq;

  always #5 clk = ~clk;

  vdp_cpu_port dut (
    .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_mode(cpu_mode),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .name_waddr(name_waddr), .name_wdata(name_wdata), .name_we(name_we),
    .pattern_waddr(pattern_waddr), .pattern_wdata(pattern_wdata), .pattern_we(pattern_we),
    .colour_waddr(colour_waddr), .colour_wdata(colour_wdata), .colour_we(colour_we),
    .vram_rd_en(vram_rd_en), .vram_rd_addr(vram_rd_addr), .vram_rd_data(vram_rd_data),
    .frame_pulse(frame_pulse), .vdp_regs(vdp_regs), .irq(irq)
  );

  // Table RAMs fed by the DUT write ports, with a 1-cycle unified read port.
  logic [7:0] name_ram    [1024] = '{default: 8'h00};
  logic [7:0] colour_ram  [1024] = '{default: 8'h00};
  logic [7:0] pattern_ram [2048] = '{default: 8'h00};

  always @(posedge clk) begin
    if (name_we)    name_ram[name_waddr]       <= name_wdata;
    if (colour_we)  colour_ram[colour_waddr]   <= colour_wdata;
    if (pattern_we) pattern_ram[pattern_waddr] <= pattern_wdata;
    if (vram_rd_en) begin
      if (vram_rd_addr < 14'h0400)      vram_rd_data <= name_ram[vram_rd_addr[9:0]];
      else if (vram_rd_addr < 14'h0800) vram_rd_data <= colour_ram[vram_rd_addr[9:0]];
      else if (vram_rd_addr < 14'h1000) vram_rd_data <= pattern_ram[vram_rd_addr[10:0]];
      else                              vram_rd_data <= 8'h00;
    end
  end

  // Reference model: VRAM as a flat byte array, registers, address, latch, flag.
  logic [7:0] mvram [16384];
  logic [7:0] mregs [8];
  int         maddr, mrdaddr;
  logic [7:0] mbyte1, mbuf, mrdata;
  bit         mhave, mflag;
  int         e_tgt, e_loc, e_pfaddr;
  logic [7:0] e_data;
  bit         e_pf;
  int         n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_regs();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = mregs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    maddr = 0; mrdaddr = 0; mbyte1 = 0; mbuf = 0; mrdata = 0; mhave = 0; mflag = 0;
  endtask

  task automatic prefetch();
    e_pf = 1; e_pfaddr = maddr; mrdaddr = maddr; mbuf = mvram[maddr];
  endtask

  task automatic model_op(input bit w, input bit r, input bit m, input logic [7:0] d, input bit fp);
    e_tgt = 0; e_loc = 0; e_data = d; e_pf = 0; e_pfaddr = 0;
    if (w && !m) begin
      mhave = 0;
      if (maddr < 'h400)       begin e_tgt = 1; e_loc = maddr;         end
      else if (maddr < 'h800)  begin e_tgt = 2; e_loc = maddr - 'h400; end
      else if (maddr < 'h1000) begin e_tgt = 3; e_loc = maddr - 'h800; end
      if (e_tgt != 0) mvram[maddr] = d;
      mbuf  = d;
      maddr = (maddr + 1) % 16384;
    end else if (w) begin
      if (!mhave) begin
        mbyte1 = d; mhave = 1;
      end else begin
        mhave = 0;
        if (d[7:6] == 2'b10) mregs[d[2:0]] = mbyte1;
        else if (d[7:6] != 2'b11) begin
          maddr = int'(d[5:0]) * 256 + int'(mbyte1);
          if (RB && d[7:6] == 2'b00) prefetch();
        end
      end
    end else if (r && !m) begin
      mhave  = 0;
      mrdata = RB ? mbuf : 8'h00;
      maddr  = (maddr + 1) % 16384;
      if (RB) prefetch();
    end else if (r) begin
      mhave  = 0;
      mrdata = mflag ? 8'h80 : 8'h00;
      mflag  = 0;
    end
    if (fp) mflag = 1;
  endtask

  task automatic check_n1();
    chk("name_we", name_we, e_tgt == 1);
    chk("colour_we", colour_we, e_tgt == 2);
    chk("pattern_we", pattern_we, e_tgt == 3);
    if (e_tgt == 1) begin chk("name_waddr", name_waddr, e_loc); chk("name_wdata", name_wdata, e_data); end
    if (e_tgt == 2) begin chk("colour_waddr", colour_waddr, e_loc); chk("colour_wdata", colour_wdata, e_data); end
    if (e_tgt == 3) begin chk("pattern_waddr", pattern_waddr, e_loc); chk("pattern_wdata", pattern_wdata, e_data); end
    chk("vdp_regs", vdp_regs, exp_regs());
    chk("irq", irq, mflag & mregs[1][5]);
    chk("cpu_rdata", cpu_rdata, mrdata);
    chk("vram_rd_en", vram_rd_en, e_pf);
    chk("vram_rd_addr", vram_rd_addr, mrdaddr);
  endtask

  // One strobe at cycle N, checks at N+1 and N+2, next strobe no earlier than N+4.
  task automatic op(input bit w, input bit r, input bit m, input logic [7:0] d, input bit fp);
    model_op(w, r, m, d, fp);
    @(negedge clk);
    cpu_wr = w; cpu_rd = r; cpu_mode = m; cpu_wdata = d; frame_pulse = fp;
    @(negedge clk);
    cpu_wr = 0; cpu_rd = 0; frame_pulse = 0;
    check_n1();
    @(negedge clk);
    chk("we_one_cycle", {name_we, colour_we, pattern_we}, 3'b000);
    chk("rd_en_one_cycle", vram_rd_en, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mvram[i] = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_we", {name_we, colour_we, pattern_we}, 0);
    chk("rst_rd_en", vram_rd_en, 0);
    chk("rst_rd_addr", vram_rd_addr, 0);
    chk("rst_regs", vdp_regs, 0);
    chk("rst_irq", irq, 0);
    reset = 0;

    // Write setup and burst; third write proves the counter reached 2.
    op(1,0,1,8'h00,0); op(1,0,1,8'h40,0);
    op(1,0,0,8'hAA,0); op(1,0,0,8'hBB,0); op(1,0,0,8'hCC,0);
    // R1 = 0x20
    op(1,0,1,8'h20,0); op(1,0,1,8'h81,0);
    // Colour/pattern boundary, then unmapped top address wrapping to 0
    op(1,0,1,8'hFF,0); op(1,0,1,8'h47,0); op(1,0,0,8'h11,0); op(1,0,0,8'h22,0);
    op(1,0,1,8'hFF,0); op(1,0,1,8'h7F,0); op(1,0,0,8'h33,0); op(1,0,0,8'h44,0);
    // Readback: pattern 0x005 = 0x5A, 0x006 = 0x99, read setup 0x0805
    op(1,0,1,8'h05,0); op(1,0,1,8'h48,0); op(1,0,0,8'h5A,0); op(1,0,0,8'h99,0);
    op(1,0,1,8'h05,0); op(1,0,1,8'h08,0);
    op(0,1,0,8'h00,0); op(0,1,0,8'h00,0);
    // Status and IRQ, including reads coincident with frame_pulse
    op(0,0,0,8'h00,1); op(0,1,1,8'h00,0); op(0,1,1,8'h00,0);
    op(0,1,1,8'h00,1); op(0,1,1,8'h00,1); op(0,1,1,8'h00,0);
    // Latch reset by a data access
    op(1,0,1,8'h12,0); op(0,1,0,8'h00,0); op(1,0,1,8'h34,0); op(1,0,1,8'h40,0);
    op(1,0,0,8'h66,0);
    // Simultaneous write and read: write wins
    op(1,1,0,8'h77,0); op(1,1,1,8'h01,0); op(1,1,1,8'h82,0);

    // Strobe one cycle after a data read: dropped only while a prefetch is in flight
    model_op(0,1,0,8'h00,0);
    @(negedge clk); cpu_rd = 1; cpu_mode = 0;
    @(negedge clk); cpu_rd = 0; cpu_wr = 1; cpu_wdata = 8'h5C;
    check_n1();
    e_tgt = 0;
    if (!RB) model_op(1,0,0,8'h5C,0);
    @(negedge clk); cpu_wr = 0;
    chk("drop_name_we", name_we, e_tgt == 1);
    chk("drop_colour_we", colour_we, e_tgt == 2);
    chk("drop_pattern_we", pattern_we, e_tgt == 3);
    repeat (2) @(negedge clk);
    op(1,0,0,8'h5D,0);

    for (int i = 0; i < 400; i++) begin
      int         k;
      logic [7:0] d;
      bit         fp;
      k  = $urandom_range(0, 9);
      d  = 8'($urandom);
      fp = ($urandom_range(0, 7) == 0);
      case (k)
        0, 1, 2, 3: op(1,0,0,d,fp);
        4, 5: begin
          if ($urandom_range(0, 3) != 0) d[5:4] = 2'b00;
          op(1,0,1,d,fp);
        end
        6, 7: op(0,1,0,d,fp);
        8: op(0,1,1,d,fp);
        default: op(1,1,1'($urandom_range(0, 1)),d,fp);
      endcase
    end

    // Reset while a prefetch is being issued
    model_op(0,1,0,8'h00,0);
    @(negedge clk); cpu_rd = 1; cpu_mode = 0;
    @(negedge clk); cpu_rd = 0; reset = 1;
    chk("pf_issue", vram_rd_en, e_pf);
    @(negedge clk); reset = 0;
    model_reset();
    chk("mid_rst_rd_en", vram_rd_en, 0);
    chk("mid_rst_rd_addr", vram_rd_addr, 0);
    chk("mid_rst_rdata", cpu_rdata, 0);
    chk("mid_rst_regs", vdp_regs, 0);
    repeat (2) @(negedge clk);
    op(0,1,0,8'h00,0); op(0,1,0,8'h00,0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
